hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 4: stall cycles after a multiply issues.
REQ-002 Parameter DIV_LAT, default 32: stall cycles after a divide issues.
REQ-003 Port clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-004 Port rst  in  1  reset, asynchronous and active-high.
REQ-005 Port ID_rs, ID_rt  in  5 each  source registers of the instruction in IF/ID.
REQ-006 Port ID_uses_rt  in  1  the ID instruction reads rt as a source.
REQ-007 Port ID_md_start, ID_md_div  in  1 each  the ID instruction is a mult/div; 1 = divide.
REQ-008 Port IDEX_MemRead  in  1, IDEX_rt  in  5  load in ID/EX and its destination register.
REQ-009 Port EM_PCSrc  in  1, EM_jump  in  2  branch taken / jump type from EX/MEM.
REQ-010 Port PCWrite, IFWrite  out  1 each  PC and IF/ID write enables.
REQ-011 Port IDEX_bubble  out  1  zero the ID/EX control fields next edge.
REQ-012 Port IFID_flush  out  1  redirect indication (flush IF/ID, bubble ID/EX).
REQ-013 Port md_busy  out  1  multiply/divide stall in progress.
REQ-014 Port stall_cycles, flush_cycles  out  16 each  saturating performance counters.

Function
REQ-015 redirect = EM_PCSrc | (EM_jump==1) | (EM_jump==2); EM_jump==0 or 3 is no redirect.
REQ-016 loaduse = IDEX_MemRead & (IDEX_rt!=0) & (IDEX_rt==ID_rs | (ID_uses_rt & IDEX_rt==ID_rt)).
REQ-017 Two states: RUN, MD_STALL; 6-bit down-counter cnt.
REQ-018 All outputs except the counters are combinational from state, cnt and inputs; no added latency.
REQ-019 RUN, redirect: PCWrite=1, IFWrite=1, IFID_flush=1, IDEX_bubble=1; remain RUN; loaduse and ID_md_start ignored (wrong-path).
REQ-020 RUN, no redirect, loaduse: PCWrite=0, IFWrite=0, IDEX_bubble=1, IFID_flush=0 for that cycle; remain RUN; ID_md_start ignored this cycle.
REQ-021 RUN, no redirect, no loaduse, ID_md_start: PCWrite=1, IFWrite=1, IDEX_bubble=0; next state MD_STALL; cnt loads DIV_LAT if ID_md_div else MULT_LAT.
REQ-022 RUN otherwise: PCWrite=1, IFWrite=1, IDEX_bubble=0, IFID_flush=0.
REQ-023 MD_STALL: md_busy=1, PCWrite=0, IFWrite=0, IDEX_bubble=1; cnt decrements each edge; at an edge where cnt==1, next state RUN with cnt=0.
REQ-024 MD_STALL with redirect: PCWrite=1, IFID_flush=1, IDEX_bubble=1, IFWrite=0; cnt keeps decrementing; the state does not change.
REQ-025 ID_md_start is sampled only in RUN; a held mult/div in IF/ID issues after return to RUN.
REQ-026 stall_cycles increments on each edge where PCWrite==0; flush_cycles increments on each edge where IFID_flush==1; both saturate at 16'hFFFF.
REQ-027 md_busy=0 in RUN.

Reset
REQ-028 While rst=1, asynchronously: state=RUN, cnt=0, stall_cycles=0, flush_cycles=0.
REQ-029 Reset mid-MD_STALL abandons the stall: md_busy=0 immediately, and PCWrite=1 and IFWrite=1 when the inputs are idle.
REQ-030 After rst falls, the first rising edge evaluates RUN rules.

Verification
REQ-031 Scenario: IDEX_MemRead=1, IDEX_rt=8, ID_rs=8 for one cycle -> that cycle PCWrite=0, IFWrite=0, IDEX_bubble=1; next cycle all normal; stall_cycles=1.
REQ-032 Scenario: IDEX_rt=0 load with ID_rs=0 -> no stall; also ID_rt match with ID_uses_rt=0 -> no stall.
REQ-033 Scenario: ID_md_start=1, ID_md_div=0 -> md_busy=1 for exactly 4 cycles; PCWrite=0 during them; stall_cycles=4. Same with ID_md_div=1 -> 32 cycles.
REQ-034 Scenario: EM_PCSrc=1 with loaduse and ID_md_start both true -> IFID_flush=1, PCWrite=1, no stall, stays RUN; EM_jump=3 alone -> no flush.
REQ-035 Scenario: EM_jump=2 on cycle 2 of a divide stall -> IFID_flush=1, PCWrite=1, IFWrite=0 that cycle; md_busy still ends after 32 total cycles.
REQ-036 Scenario: rst pulse on cycle 10 of a divide stall, then stall_cycles preloaded near 16'hFFFF -> counters zero and RUN at once; a later long stall holds stall_cycles at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch/jump redirect flush,
// multi-cycle multiply/divide stall, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rt,
  input  logic        ID_md_start,
  input  logic        ID_md_div,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rt,
  input  logic        EM_PCSrc,
  input  logic [1:0]  EM_jump,
  output logic        PCWrite,
  output logic        IFWrite,
  output logic        IDEX_bubble,
  output logic        IFID_flush,
  output logic        md_busy,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_cycles
);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MD_STALL = 1'b1
  } state_t;

  localparam logic [5:0]  C_MULT_LAT = 6'(MULT_LAT);
  localparam logic [5:0]  C_DIV_LAT  = 6'(DIV_LAT);
  localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_cycles;

  logic w_redirect;
  logic w_rs_match;
  logic w_rt_match;
  logic w_loaduse;
  logic w_md_issue;
  logic w_pc_write;
  logic w_if_write;
  logic w_idex_bubble;
  logic w_ifid_flush;
  logic w_md_busy;

  assign w_redirect = EM_PCSrc | (EM_jump == 2'd1) | (EM_jump == 2'd2);
  assign w_rs_match = (IDEX_rt == ID_rs);
  assign w_rt_match = ID_uses_rt & (IDEX_rt == ID_rt);
  // Register 0 is hard-wired, so a load into it can never create a dependency.
  assign w_loaduse  = IDEX_MemRead & (IDEX_rt != 5'd0) & (w_rs_match | w_rt_match);
  assign w_md_issue = (r_state == S_RUN) & ~w_redirect & ~w_loaduse & ID_md_start;

  // Pipeline control decode from state and current hazard conditions
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_write    = 1'b1;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_md_busy     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_redirect) begin
          w_pc_write    = 1'b1;
          w_if_write    = 1'b1;
          w_idex_bubble = 1'b1;
          w_ifid_flush  = 1'b1;
        end else if (w_loaduse) begin
          w_pc_write    = 1'b0;
          w_if_write    = 1'b0;
          w_idex_bubble = 1'b1;
          w_ifid_flush  = 1'b0;
        end else begin
          w_pc_write    = 1'b1;
          w_if_write    = 1'b1;
          w_idex_bubble = 1'b0;
          w_ifid_flush  = 1'b0;
        end
      end
      S_MD_STALL: begin
        // A redirect still steers the PC, but the held IF/ID is left alone.
        w_md_busy     = 1'b1;
        w_if_write    = 1'b0;
        w_idex_bubble = 1'b1;
        if (w_redirect) begin
          w_pc_write   = 1'b1;
          w_ifid_flush = 1'b1;
        end else begin
          w_pc_write   = 1'b0;
          w_ifid_flush = 1'b0;
        end
      end
      default: begin
        w_pc_write    = 1'b1;
        w_if_write    = 1'b1;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        w_md_busy     = 1'b0;
      end
    endcase
  end

  // Multiply/divide stall FSM and latency down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_md_issue) begin
            r_state <= S_MD_STALL;
            r_cnt   <= ID_md_div ? C_DIV_LAT : C_MULT_LAT;
          end else begin
            r_state <= S_RUN;
            r_cnt   <= 6'd0;
          end
        end
        S_MD_STALL: begin
          if (r_cnt <= 6'd1) begin
            r_state <= S_RUN;
            r_cnt   <= 6'd0;
          end else begin
            r_state <= S_MD_STALL;
            r_cnt   <= r_cnt - 6'd1;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end

  // Saturating performance counters for stalled and flushed cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 16'd0;
      r_flush_cycles <= 16'd0;
    end else begin
      if (!w_pc_write && (r_stall_cycles != C_CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (w_ifid_flush && (r_flush_cycles != C_CNT_MAX)) begin
        r_flush_cycles <= r_flush_cycles + 16'd1;
      end else begin
        r_flush_cycles <= r_flush_cycles;
      end
    end
  end

  assign PCWrite      = w_pc_write;
  assign IFWrite      = w_if_write;
  assign IDEX_bubble  = w_idex_bubble;
  assign IFID_flush   = w_ifid_flush;
  assign md_busy      = w_md_busy;
  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;

endmodule
